// File: rtl/sd_emmc_cmd_resp_rx.sv
// eMMC CMD-line response receiver: waits for the device start bit, deserialises
// R1/R1b/R3 (48-bit) or R2 (136-bit) responses and checks CRC7, end, tx and index.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no command outstanding, finish_o low
// ST_WAIT    | armed, counting Ncr cycles until the start bit
// ST_RECV    | shifting response bits after the start bit
// ST_DONE    | result held, finish_o high until the next start_i or abort_i
module sd_emmc_cmd_resp_rx #(
    parameter int NCR_MAX = 64,
    parameter int CNT_W   = 8
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [1:0]   setting_i,
    input  logic [5:0]   cmd_index_i,
    input  logic         cmd_dat_i,
    output logic [119:0] response_o,
    output logic         crc_ok_o,
    output logic         index_ok_o,
    output logic         timeout_o,
    output logic         finish_o,
    output logic         busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic             long_q;
    logic [5:0]       idx_q;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] wait_next;
    logic [CNT_W-1:0] last_bit;
    logic [6:0]       crc_q;
    logic [133:0]     shreg;
    logic             crc_feed;
    logic             rx_tx;
    logic [5:0]       rx_idx;
    logic [6:0]       rx_crc;
    logic [119:0]     rx_resp;
    logic             rx_idx_ok;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic d);
        logic fb;
        fb = d ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    assign busy_o    = (state == ST_WAIT) || (state == ST_RECV);
    assign wait_next = wait_cnt + 1'b1;
    assign last_bit  = long_q ? CNT_W'(134) : CNT_W'(46);

    // short: CRC spans tx, index, argument (bits 0..38); long: payload only (7..126)
    always_comb begin
        crc_feed = 1'b0;
        if (long_q)
            crc_feed = (bit_cnt >= CNT_W'(7)) && (bit_cnt <= CNT_W'(126));
        else
            crc_feed = (bit_cnt <= CNT_W'(38));
    end

    // At the end-bit cycle shreg holds every bit before the end bit, LSB = newest.
    always_comb begin
        rx_tx     = 1'b0;
        rx_idx    = 6'h00;
        rx_crc    = 7'h00;
        rx_resp   = '0;
        rx_idx_ok = 1'b0;
        if (long_q) begin
            rx_tx     = shreg[133];
            rx_idx    = shreg[132:127];
            rx_resp   = shreg[126:7];
            rx_crc    = shreg[6:0];
            rx_idx_ok = !rx_tx && (rx_idx == 6'h3F);
        end else begin
            rx_tx     = shreg[45];
            rx_idx    = shreg[44:39];
            rx_resp   = {shreg[38:7], 88'h0};
            rx_crc    = shreg[6:0];
            rx_idx_ok = !rx_tx && (rx_idx == idx_q);
        end
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            long_q     <= 1'b0;
            idx_q      <= 6'h00;
            wait_cnt   <= '0;
            bit_cnt    <= '0;
            crc_q      <= 7'h00;
            shreg      <= '0;
            response_o <= '0;
            crc_ok_o   <= 1'b0;
            index_ok_o <= 1'b0;
            timeout_o  <= 1'b0;
            finish_o   <= 1'b0;
        end else if (abort_i && (state != ST_IDLE)) begin
            state    <= ST_IDLE;
            finish_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i && !abort_i) begin
                        long_q     <= setting_i[1];
                        idx_q      <= cmd_index_i;
                        finish_o   <= 1'b0;
                        crc_ok_o   <= 1'b0;
                        index_ok_o <= 1'b0;
                        timeout_o  <= 1'b0;
                        wait_cnt   <= '0;
                        bit_cnt    <= '0;
                        crc_q      <= 7'h00;
                        shreg      <= '0;
                        state      <= setting_i[0] ? ST_WAIT : ST_DONE;
                    end else if (state == ST_DONE) begin
                        finish_o <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!cmd_dat_i) begin
                        crc_q   <= crc7_step(crc_q, 1'b0);
                        bit_cnt <= '0;
                        state   <= ST_RECV;
                    end else begin
                        wait_cnt <= wait_next;
                        if (wait_next == CNT_W'(NCR_MAX)) begin
                            timeout_o <= 1'b1;
                            finish_o  <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_RECV: begin
                    shreg   <= {shreg[132:0], cmd_dat_i};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (crc_feed)
                        crc_q <= crc7_step(crc_q, cmd_dat_i);
                    if (bit_cnt == last_bit) begin
                        response_o <= rx_resp;
                        crc_ok_o   <= (rx_crc == crc_q) && cmd_dat_i;
                        index_ok_o <= rx_idx_ok;
                        state      <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_emmc_cmd_resp_rx.sv
// Directed bench for sd_emmc_cmd_resp_rx: table of response frames plus
// hand-written timeout, no-response, abort and async-reset sequences.
module tb_sd_emmc_cmd_resp_rx;

    logic         sd_clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_i = 1'b0;
    logic         abort_i = 1'b0;
    logic [1:0]   setting_i = 2'b00;
    logic [5:0]   cmd_index_i = 6'h00;
    logic         cmd_dat_i = 1'b1;
    logic [119:0] response_o;
    logic         crc_ok_o;
    logic         index_ok_o;
    logic         timeout_o;
    logic         finish_o;
    logic         busy_o;

    int n_run  = 0;
    int n_fail = 0;
    logic [119:0] last_resp = '0;

    localparam logic [119:0] P = 120'h01_2345_6789_ABCD_EF01_2345_6789_CDEF;

    sd_emmc_cmd_resp_rx #(.NCR_MAX(64), .CNT_W(8)) dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .setting_i   (setting_i),
        .cmd_index_i (cmd_index_i),
        .cmd_dat_i   (cmd_dat_i),
        .response_o  (response_o),
        .crc_ok_o    (crc_ok_o),
        .index_ok_o  (index_ok_o),
        .timeout_o   (timeout_o),
        .finish_o    (finish_o),
        .busy_o      (busy_o)
    );

    always #5 sd_clk = ~sd_clk;

    typedef struct {
        logic         long_r;
        logic [5:0]   cmd_idx;
        logic         tx;
        logic [5:0]   idx_f;
        logic [119:0] data;
        logic [119:0] flip;
        logic         end_b;
        int           delay;
        logic [119:0] exp_resp;
        logic         exp_crc;
        logic         exp_idx;
    } vec_t;

    vec_t tv [9];

    task automatic check1(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkw(input string name, input logic [119:0] act, input logic [119:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
        logic [6:0] c;
        logic fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [135:0] build(input vec_t v);
        logic [39:0]  hdr;
        logic [6:0]   c;
        logic [119:0] pd;
        if (v.long_r) begin
            c  = crc7({16'h0, v.data}, 120);
            pd = v.data ^ v.flip;
            return {1'b0, v.tx, v.idx_f, pd, c, v.end_b};
        end else begin
            hdr = {1'b0, v.tx, v.idx_f, v.data[31:0]};
            c   = crc7({96'h0, hdr}, 40);
            pd  = v.data ^ v.flip;
            return {89'h0, v.tx, v.idx_f, pd[31:0], c, v.end_b};
        end
    endfunction

    task automatic arm(input logic [1:0] s, input logic [5:0] idx);
        @(negedge sd_clk);
        start_i     = 1'b1;
        setting_i   = s;
        cmd_index_i = idx;
        @(negedge sd_clk);
        start_i     = 1'b0;
    endtask

    // Drives the start bit on edge d after arming, then cnt frame bits MSB first.
    task automatic send_bits(input logic [135:0] f, input int n, input int cnt, input int d);
        for (int k = 0; k < d - 1; k++) @(negedge sd_clk);
        cmd_dat_i = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            @(negedge sd_clk);
            cmd_dat_i = f[n-1-i];
        end
        @(negedge sd_clk);
        cmd_dat_i = 1'b1;
    endtask

    task automatic run_vector(input int i);
        vec_t v;
        logic [135:0] f;
        int n;
        v = tv[i];
        f = build(v);
        n = v.long_r ? 135 : 47;
        arm({v.long_r, 1'b1}, v.cmd_idx);
        check1($sformatf("v%0d finish_cleared", i), finish_o, 1'b0);
        check1($sformatf("v%0d busy_armed", i), busy_o, 1'b1);
        send_bits(f, n, n, v.delay);
        checkw($sformatf("v%0d response", i), response_o, v.exp_resp);
        check1($sformatf("v%0d crc_ok", i), crc_ok_o, v.exp_crc);
        check1($sformatf("v%0d index_ok", i), index_ok_o, v.exp_idx);
        check1($sformatf("v%0d timeout", i), timeout_o, 1'b0);
        check1($sformatf("v%0d busy_end", i), busy_o, 1'b0);
        check1($sformatf("v%0d finish_at_end_edge", i), finish_o, 1'b0);
        @(negedge sd_clk);
        check1($sformatf("v%0d finish", i), finish_o, 1'b1);
        repeat (3) @(negedge sd_clk);
        check1($sformatf("v%0d finish_held", i), finish_o, 1'b1);
        checkw($sformatf("v%0d response_held", i), response_o, v.exp_resp);
        last_resp = v.exp_resp;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [135:0] f;

        tv[0] = '{1'b0, 6'd3, 1'b0, 6'd3, 120'h0000_0500, 120'h0, 1'b1, 5, {32'h0000_0500, 88'h0}, 1'b1, 1'b1};
        tv[1] = '{1'b0, 6'd3, 1'b0, 6'd3, 120'h0000_0500, 120'h1, 1'b1, 5, {32'h0000_0501, 88'h0}, 1'b0, 1'b1};
        tv[2] = '{1'b0, 6'd3, 1'b0, 6'd3, 120'h0000_0500, 120'h0, 1'b0, 5, {32'h0000_0500, 88'h0}, 1'b0, 1'b1};
        tv[3] = '{1'b0, 6'd3, 1'b0, 6'd4, 120'h1234_5678, 120'h0, 1'b1, 3, {32'h1234_5678, 88'h0}, 1'b1, 1'b0};
        tv[4] = '{1'b0, 6'd7, 1'b1, 6'd7, 120'hDEAD_BEEF, 120'h0, 1'b1, 1, {32'hDEAD_BEEF, 88'h0}, 1'b1, 1'b0};
        tv[5] = '{1'b1, 6'd2, 1'b0, 6'h3F, P, 120'h0, 1'b1, 5, P, 1'b1, 1'b1};
        tv[6] = '{1'b1, 6'd2, 1'b0, 6'h02, P, 120'h0, 1'b1, 2, P, 1'b1, 1'b0};
        tv[7] = '{1'b1, 6'd2, 1'b0, 6'h3F, P, 120'h1 << 60, 1'b1, 4, P ^ (120'h1 << 60), 1'b0, 1'b1};
        tv[8] = '{1'b0, 6'd13, 1'b0, 6'd13, 120'h0000_0900, 120'h0, 1'b1, 64, {32'h0000_0900, 88'h0}, 1'b1, 1'b1};

        repeat (2) @(negedge sd_clk);
        checkw("reset response", response_o, 120'h0);
        check1("reset crc_ok", crc_ok_o, 1'b0);
        check1("reset index_ok", index_ok_o, 1'b0);
        check1("reset timeout", timeout_o, 1'b0);
        check1("reset finish", finish_o, 1'b0);
        check1("reset busy", busy_o, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vector(i);

        // Ncr timeout with CMD held high
        arm(2'b01, 6'd5);
        repeat (63) @(negedge sd_clk);
        check1("to busy_63", busy_o, 1'b1);
        check1("to timeout_63", timeout_o, 1'b0);
        check1("to finish_63", finish_o, 1'b0);
        @(negedge sd_clk);
        check1("to timeout_64", timeout_o, 1'b1);
        check1("to finish_64", finish_o, 1'b1);
        check1("to busy_64", busy_o, 1'b0);
        checkw("to response", response_o, last_resp);

        // No response expected
        arm(2'b00, 6'd0);
        check1("nr busy0", busy_o, 1'b0);
        check1("nr finish0", finish_o, 1'b0);
        check1("nr timeout_cleared", timeout_o, 1'b0);
        @(negedge sd_clk);
        check1("nr finish1", finish_o, 1'b1);
        check1("nr busy1", busy_o, 1'b0);
        checkw("nr response", response_o, last_resp);

        // Abort in the middle of a short frame at bit 20
        f = build(tv[0]);
        arm(2'b01, 6'd3);
        send_bits(f, 47, 21, 5);
        check1("ab busy_before", busy_o, 1'b1);
        abort_i = 1'b1;
        @(negedge sd_clk);
        abort_i = 1'b0;
        check1("ab busy", busy_o, 1'b0);
        check1("ab finish", finish_o, 1'b0);
        checkw("ab response", response_o, last_resp);
        repeat (3) @(negedge sd_clk);
        check1("ab finish_idle", finish_o, 1'b0);
        run_vector(3);

        // Asynchronous reset during a long frame
        f = build(tv[5]);
        arm(2'b11, 6'd2);
        send_bits(f, 135, 30, 3);
        #2 rst = 1'b1;
        #1;
        checkw("rs response", response_o, 120'h0);
        check1("rs crc_ok", crc_ok_o, 1'b0);
        check1("rs index_ok", index_ok_o, 1'b0);
        check1("rs timeout", timeout_o, 1'b0);
        check1("rs finish", finish_o, 1'b0);
        check1("rs busy", busy_o, 1'b0);
        @(negedge sd_clk);
        rst = 1'b0;
        last_resp = '0;
        run_vector(5);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
